// File: rtl/wave_classifier.sv
// wave_classifier: classifies a 5-bit sample stream as square, sawtooth or
// triangle from consecutive step shapes, then measures its period between
// anchor steps once locked.
module wave_classifier #(
    parameter int LOCK_RUN = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sample_valid,
    input  logic [4:0] sample,
    output logic [1:0] wave_type,
    output logic       locked,
    output logic [6:0] period,
    output logic       period_valid,
    output logic       err
);

    // Encoding doubles as the wave_type output code.
    typedef enum logic [1:0] {
        ST_SQUARE   = 2'd0,
        ST_SAWTOOTH = 2'd1,
        ST_TRIANGLE = 2'd2,
        ST_UNKNOWN  = 2'd3
    } state_t;

    localparam logic [5:0] RUN_MAX  = 6'd63;
    localparam logic [6:0] PER_MAX  = 7'd127;
    localparam logic [5:0] LOCK_THR = 6'(LOCK_RUN);

    state_t     state, state_nxt;
    logic [4:0] prev;
    logic       have_prev;
    logic [5:0] run_sq, run_saw, run_tri;
    logic [5:0] run_sq_nxt, run_saw_nxt, run_tri_nxt;
    logic [6:0] per_cnt, per_inc;
    logic       anchor_seen;

    // Step decode. Compared at 6 bits so 31->0 is never mistaken for +1.
    logic [5:0] p6, s6;
    logic       is_hold, is_up1, is_dn1, is_jup, is_jdn;
    logic       cons_sq, cons_saw, cons_tri;
    logic       step_en, anchor, err_nxt;
    logic       qual_sq, qual_saw, qual_tri;

    assign p6      = {1'b0, prev};
    assign s6      = {1'b0, sample};
    assign is_hold = (s6 == p6);
    assign is_up1  = (s6 == p6 + 6'd1);
    assign is_dn1  = (s6 == p6 - 6'd1);
    assign is_jup  = (prev == 5'd0)  && (sample == 5'd31);
    assign is_jdn  = (prev == 5'd31) && (sample == 5'd0);

    assign cons_sq  = is_hold | is_jup | is_jdn;
    assign cons_saw = is_up1  | is_jdn;
    assign cons_tri = is_up1  | is_dn1;

    // A step exists only once a previous sample has been captured.
    assign step_en = sample_valid & have_prev;

    assign run_sq_nxt  = cons_sq  ? ((run_sq  == RUN_MAX) ? RUN_MAX : run_sq  + 6'd1) : 6'd0;
    assign run_saw_nxt = cons_saw ? ((run_saw == RUN_MAX) ? RUN_MAX : run_saw + 6'd1) : 6'd0;
    assign run_tri_nxt = cons_tri ? ((run_tri == RUN_MAX) ? RUN_MAX : run_tri + 6'd1) : 6'd0;

    assign qual_sq  = (run_sq_nxt  >= LOCK_THR);
    assign qual_saw = (run_saw_nxt >= LOCK_THR);
    assign qual_tri = (run_tri_nxt >= LOCK_THR);

    // Saturating increment shared by the period counter and period capture.
    assign per_inc = (per_cnt == PER_MAX) ? PER_MAX : per_cnt + 7'd1;

    assign wave_type = state;

    // State register plus registered lock flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_UNKNOWN;
            locked <= 1'b0;
        end else begin
            state  <= state_nxt;
            locked <= (state_nxt != ST_UNKNOWN);
        end
    end

    // Next state: lock only on an unambiguous run; any inconsistent step unlocks.
    always_comb begin
        state_nxt = state;
        err_nxt   = 1'b0;
        anchor    = 1'b0;
        if (step_en) begin
            case (state)
                ST_UNKNOWN: begin
                    if (qual_sq && !qual_saw && !qual_tri)
                        state_nxt = ST_SQUARE;
                    else if (qual_saw && !qual_sq && !qual_tri)
                        state_nxt = ST_SAWTOOTH;
                    else if (qual_tri && !qual_sq && !qual_saw)
                        state_nxt = ST_TRIANGLE;
                end
                ST_SQUARE: begin
                    if (!cons_sq) begin
                        state_nxt = ST_UNKNOWN;
                        err_nxt   = 1'b1;
                    end else begin
                        anchor = is_jup;
                    end
                end
                ST_SAWTOOTH: begin
                    if (!cons_saw) begin
                        state_nxt = ST_UNKNOWN;
                        err_nxt   = 1'b1;
                    end else begin
                        anchor = is_jdn;
                    end
                end
                ST_TRIANGLE: begin
                    if (!cons_tri) begin
                        state_nxt = ST_UNKNOWN;
                        err_nxt   = 1'b1;
                    end else begin
                        anchor = is_dn1 && (prev == 5'd31);
                    end
                end
                default: state_nxt = ST_UNKNOWN;
            endcase
        end
    end

    // History, run counters and period measurement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev         <= 5'd0;
            have_prev    <= 1'b0;
            run_sq       <= 6'd0;
            run_saw      <= 6'd0;
            run_tri      <= 6'd0;
            per_cnt      <= 7'd0;
            anchor_seen  <= 1'b0;
            period       <= 7'd0;
            period_valid <= 1'b0;
            err          <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            err          <= err_nxt;
            if (sample_valid) begin
                prev      <= sample;
                have_prev <= 1'b1;
            end
            if (step_en) begin
                run_sq  <= run_sq_nxt;
                run_saw <= run_saw_nxt;
                run_tri <= run_tri_nxt;
                if (err_nxt) begin
                    per_cnt     <= 7'd0;
                    anchor_seen <= 1'b0;
                end else if (state != ST_UNKNOWN) begin
                    if (anchor) begin
                        if (anchor_seen) begin
                            period       <= per_inc;
                            period_valid <= 1'b1;
                        end
                        per_cnt     <= 7'd0;
                        anchor_seen <= 1'b1;
                    end else begin
                        per_cnt <= per_inc;
                    end
                end
            end
        end
    end

endmodule
